// File: rtl/connect4_pkg.sv
// Shared constants and FSM state type for the Connect Four move sequencer.
package connect4_pkg;

  localparam int unsigned COLS         = 8;
  localparam int unsigned ROWS         = 8;
  localparam int unsigned CELLS        = 64;
  localparam int unsigned TOP_ROW_BASE = 56;

  localparam logic [1:0] WINNER_NONE = 2'd0;
  localparam logic [1:0] WINNER_P0   = 2'd1;
  localparam logic [1:0] WINNER_P1   = 2'd2;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  // Column c is presented on bit 7-c of the engine's one-hot move bus.
  function automatic logic [7:0] col_onehot(input logic [2:0] col);
    return 8'h80 >> col;
  endfunction

endpackage

// File: rtl/connect4_move_sequencer_if.sv
// Move interface between the sequencer (master) and the game engine (slave).
interface connect4_move_sequencer_if;
  import connect4_pkg::*;

  logic [7:0]       player_input;
  logic             player;
  logic             start;
  logic [CELLS-1:0] cell_empty;
  logic [1:0]       winner;
  logic             error;

  modport master (
    output player_input, player, start,
    input  cell_empty, winner, error
  );

  modport slave (
    input  player_input, player, start,
    output cell_empty, winner, error
  );

endinterface

// File: rtl/connect4_cursor.sv
// Saturating 3-bit column cursor; opposing buttons in one cycle cancel out.
module connect4_cursor
  import connect4_pkg::*;
#(
  parameter int unsigned CURSOR_INIT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic       en,
  input  logic       left,
  input  logic       right,
  output logic [2:0] cursor
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cursor <= 3'(CURSOR_INIT);
    end else if (init) begin
      cursor <= 3'(CURSOR_INIT);
    end else if (en && left && !right && cursor != 3'd0) begin
      cursor <= cursor - 3'd1;
    end else if (en && right && !left && cursor != 3'(COLS - 1)) begin
      cursor <= cursor + 3'd1;
    end
  end

endmodule

// File: rtl/connect4_move_sequencer.sv
// Turns cursor/drop buttons into engine moves, tracks turns and detects game end.
module connect4_move_sequencer
  import connect4_pkg::*;
#(
  parameter int unsigned START_HOLD  = 2,
  parameter int unsigned RESP_WAIT   = 4,
  parameter int unsigned CURSOR_INIT = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      btn_left,
  input  logic                      btn_right,
  input  logic                      btn_drop,
  input  logic                      new_game,
  connect4_move_sequencer_if.master eng,
  output logic [2:0]                cursor,
  output logic                      move_rej,
  output logic [6:0]                move_count,
  output logic                      game_over,
  output logic                      draw
);

  state_e     state;
  logic [7:0] cnt;
  logic [5:0] top_idx;
  logic       col_full;
  logic       resp_bad;
  logic       resp_win;
  logic [6:0] next_count;
  logic       restart;

  assign top_idx    = 6'(TOP_ROW_BASE) + {3'd0, cursor};
  assign col_full   = !eng.cell_empty[top_idx];
  assign resp_bad   = eng.error || (eng.winner == 2'd3);
  assign resp_win   = (eng.winner == WINNER_P0) || (eng.winner == WINNER_P1);
  assign next_count = move_count + 7'd1;
  assign restart    = (state == StDone) && new_game;

  connect4_cursor #(
    .CURSOR_INIT(CURSOR_INIT)
  ) u_cursor (
    .clk   (clk),
    .reset (reset),
    .init  (restart),
    .en    (state == StIdle),
    .left  (btn_left),
    .right (btn_right),
    .cursor(cursor)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= StIdle;
      cnt              <= '0;
      eng.start        <= 1'b0;
      eng.player_input <= '0;
      eng.player       <= 1'b0;
      move_rej         <= 1'b0;
      move_count       <= '0;
      game_over        <= 1'b0;
      draw             <= 1'b0;
    end else begin
      move_rej <= 1'b0;
      case (state)
        StIdle: begin
          if (btn_drop) begin
            if (col_full) begin
              move_rej <= 1'b1;
            end else begin
              // The one-hot register doubles as the latched column for this move.
              eng.player_input <= col_onehot(cursor);
              eng.start        <= 1'b1;
              cnt              <= '0;
              state            <= StIssue;
            end
          end
        end
        StIssue: begin
          if (cnt == 8'(START_HOLD - 1)) begin
            eng.start        <= 1'b0;
            eng.player_input <= '0;
            cnt              <= '0;
            state            <= StWait;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StWait: begin
          if (cnt == 8'(RESP_WAIT)) begin
            cnt <= '0;
            if (resp_bad) begin
              move_rej <= 1'b1;
              state    <= StIdle;
            end else begin
              move_count <= next_count;
              if (resp_win) begin
                game_over <= 1'b1;
                state     <= StDone;
              end else if (next_count == 7'(CELLS)) begin
                game_over <= 1'b1;
                draw      <= 1'b1;
                state     <= StDone;
              end else begin
                eng.player <= ~eng.player;
                state      <= StIdle;
              end
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StDone: begin
          if (new_game) begin
            eng.player <= 1'b0;
            move_count <= '0;
            game_over  <= 1'b0;
            draw       <= 1'b0;
            state      <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_connect4_move_sequencer.sv
// Scoreboard bench: a board-height model predicts each issued move, rejection and game end.
module tb_connect4_move_sequencer;

  localparam int START_HOLD  = 2;
  localparam int RESP_WAIT   = 4;
  localparam int CURSOR_INIT = 3;
  localparam int K_ISSUE = 0;
  localparam int K_REJ   = 1;
  localparam int K_DONE  = 2;

  typedef struct {
    int         kind;
    logic [7:0] pi;
    logic       pl;
    logic [6:0] cnt;
    logic       drw;
  } ev_t;

  logic       clk;
  logic       reset;
  logic       btn_left, btn_right, btn_drop, new_game;
  logic [2:0] cursor;
  logic       move_rej;
  logic [6:0] move_count;
  logic       game_over;
  logic       draw;

  connect4_move_sequencer_if bus ();

  connect4_move_sequencer #(
    .START_HOLD (START_HOLD),
    .RESP_WAIT  (RESP_WAIT),
    .CURSOR_INIT(CURSOR_INIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_drop  (btn_drop),
    .new_game  (new_game),
    .eng       (bus),
    .cursor    (cursor),
    .move_rej  (move_rej),
    .move_count(move_count),
    .game_over (game_over),
    .draw      (draw)
  );

  int  total = 0;
  int  bad = 0;
  ev_t exp_q[$];

  // Reference model: column heights, cursor, turn, accepted-move count.
  int  heights[8];
  int  m_cur;
  int  m_count;
  bit  m_player;
  bit  m_done;
  bit  m_draw;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] pi, input logic pl, input int cnt,
                      input logic drw);
    ev_t e;
    e.kind = kind;
    e.pi   = pi;
    e.pl   = pl;
    e.cnt  = 7'(cnt);
    e.drw  = drw;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d want none at %0t", kind, $time);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      chk("event_player", 64'(bus.player), 64'(e.pl));
      chk("event_count", 64'(move_count), 64'(e.cnt));
      if (kind == K_ISSUE) chk("issue_onehot", 64'(bus.player_input), 64'(e.pi));
      if (kind == K_REJ) chk("rej_no_start", 64'(bus.start), 64'd0);
      if (kind == K_DONE) chk("done_draw", 64'(draw), 64'(e.drw));
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a move, rejection or game end.
  logic prev_start = 1'b0;
  logic prev_go = 1'b0;
  int   hi_cnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      hi_cnt = 0;
    end else begin
      if (bus.start && !prev_start) check_event(K_ISSUE);
      if (move_rej) check_event(K_REJ);
      if (game_over && !prev_go) check_event(K_DONE);
      if (bus.start) hi_cnt++;
      if (!bus.start && prev_start) begin
        chk("start_hold", 64'(hi_cnt), 64'(START_HOLD));
        hi_cnt = 0;
      end
    end
    prev_start = bus.start;
    prev_go    = game_over;
  end

  task automatic update_board();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        bus.cell_empty[r*8+c] = (r >= heights[c]);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 8; c++) heights[c] = 0;
    m_cur    = CURSOR_INIT;
    m_count  = 0;
    m_player = 1'b0;
    m_done   = 1'b0;
    m_draw   = 1'b0;
    update_board();
  endtask

  task automatic tick_press(input bit l, input bit r, input bit d, input bit ng);
    @(posedge clk);
    #1;
    btn_left = l; btn_right = r; btn_drop = d; new_game = ng;
    @(posedge clk);
    #1;
    btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0; new_game = 1'b0;
  endtask

  task automatic model_cursor(input bit l, input bit r);
    if (!m_done) begin
      if (l && !r && m_cur > 0) m_cur--;
      else if (r && !l && m_cur < 7) m_cur++;
    end
  endtask

  task automatic nav(input bit l, input bit r);
    tick_press(l, r, 1'b0, 1'b0);
    model_cursor(l, r);
  endtask

  task automatic go_to(input int target);
    int guard = 0;
    while (m_cur != target && guard < 40) begin
      guard++;
      if ($urandom % 6 == 0) nav(1'b1, 1'b1);
      else nav(m_cur > target, m_cur < target);
    end
    chk("go_to_cursor", 64'(cursor), 64'(target));
  endtask

  task automatic do_move(input bit l, input bit r, input bit err, input logic [1:0] win);
    int col = m_cur;
    bit full = (heights[col] >= 8);
    if (full) begin
      push(K_REJ, 8'h00, m_player, m_count, 1'b0);
    end else begin
      push(K_ISSUE, 8'(8'h80 >> col), m_player, m_count, 1'b0);
      if (err || win == 2'd3) begin
        push(K_REJ, 8'h00, m_player, m_count, 1'b0);
      end else begin
        m_count++;
        heights[col]++;
        if (win == 2'd1 || win == 2'd2) begin
          m_done = 1'b1;
          push(K_DONE, 8'h00, m_player, m_count, 1'b0);
        end else if (m_count == 64) begin
          m_done = 1'b1;
          m_draw = 1'b1;
          push(K_DONE, 8'h00, m_player, m_count, 1'b1);
        end else begin
          m_player = ~m_player;
        end
      end
    end
    bus.error  = err;
    bus.winner = win;
    @(posedge clk);
    #1;
    btn_left = l; btn_right = r; btn_drop = 1'b1;
    @(posedge clk);
    #1;
    btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0;
    if (!full) chk("start_latency", 64'(bus.start), 64'd1);
    // Cursor buttons beside a drop still move the cursor; the drop used the old column.
    if (!full || !m_done) begin
      if (l && !r && m_cur > 0) m_cur--;
      else if (r && !l && m_cur < 7) m_cur++;
    end
    repeat (full ? 2 : START_HOLD + RESP_WAIT + 2) @(posedge clk);
    #1;
    bus.error  = 1'b0;
    bus.winner = 2'd0;
    update_board();
  endtask

  initial begin
    int iter;
    int cand[$];
    reset = 1'b1;
    btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0; new_game = 1'b0;
    bus.error = 1'b0; bus.winner = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", 64'(bus.start), 64'd0);
    chk("rst_player_input", 64'(bus.player_input), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_cursor", 64'(cursor), 64'(m_cur));
    chk("rst_player", 64'(bus.player), 64'(m_player));
    chk("rst_count", 64'(move_count), 64'(m_count));
    chk("rst_game_over", 64'(game_over), 64'(m_done));
    chk("rst_draw", 64'(draw), 64'(m_draw));

    // Left saturation, then a drop in column 0.
    repeat (4) nav(1'b1, 1'b0);
    chk("cursor_sat_left", 64'(cursor), 64'(m_cur));
    do_move(1'b0, 1'b0, 1'b0, 2'd0);
    chk("turn_toggle", 64'(bus.player), 64'(m_player));

    // Engine error at cursor 3, then a normal drop there.
    go_to(3);
    do_move(1'b0, 1'b0, 1'b1, 2'd0);
    do_move(1'b0, 1'b0, 1'b0, 2'd0);
    nav(1'b0, 1'b0);
    new_game = 1'b1;
    @(posedge clk);
    #1;
    new_game = 1'b0;
    chk("new_game_ignored", 64'(move_count), 64'(m_count));

    // Play up to the 7th move and let player win on it; winner=3 counts as error.
    while (m_count < 6) do_move(1'($urandom % 2), 1'($urandom % 2), 1'b0, 2'd0);
    do_move(1'b0, 1'b0, 1'b0, 2'd3);
    do_move(1'b0, 1'b0, 1'b0, 2'd1);
    chk("win_count", 64'(move_count), 64'd7);
    nav(1'b1, 1'b0);
    tick_press(1'b0, 1'b0, 1'b1, 1'b0);
    chk("done_cursor_frozen", 64'(cursor), 64'(m_cur));
    chk("done_game_over", 64'(game_over), 64'(m_done));
    tick_press(1'b0, 1'b0, 1'b0, 1'b1);
    model_reset();
    chk("ng_cursor", 64'(cursor), 64'(m_cur));
    chk("ng_player", 64'(bus.player), 64'(m_player));
    chk("ng_count", 64'(move_count), 64'(m_count));
    chk("ng_game_over", 64'(game_over), 64'(m_done));

    // Two moves, then reset while the third is being issued.
    do_move(1'b0, 1'b0, 1'b0, 2'd0);
    do_move(1'b1, 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    btn_drop = 1'b1;
    @(posedge clk);
    #1;
    btn_drop = 1'b0;
    chk("mid_issue_start", 64'(bus.start), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst_start", 64'(bus.start), 64'd0);
    chk("async_rst_onehot", 64'(bus.player_input), 64'd0);
    chk("async_rst_count", 64'(move_count), 64'(m_count));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fill column 7, then a drop there must be refused.
    go_to(7);
    repeat (8) do_move(1'b0, 1'b0, 1'b0, 2'd0);
    do_move(1'b0, 1'b0, 1'b0, 2'd0);
    chk("full_col_cursor", 64'(cursor), 64'(m_cur));

    // Random play to a full board with occasional engine errors and full-column drops.
    iter = 0;
    while (!m_done && iter < 2000) begin
      iter++;
      cand.delete();
      if ($urandom % 10 == 0) begin
        for (int c = 0; c < 8; c++) if (heights[c] >= 8) cand.push_back(c);
      end
      if (cand.size() == 0) begin
        for (int c = 0; c < 8; c++) if (heights[c] < 8) cand.push_back(c);
      end
      go_to(cand[$urandom_range(0, cand.size() - 1)]);
      do_move(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0, 2'd0);
    end
    chk("fill_reached_end", 64'(m_done), 64'd1);
    chk("draw_flag", 64'(draw), 64'(m_draw));
    chk("draw_game_over", 64'(game_over), 64'(m_done));
    chk("draw_count", 64'(move_count), 64'(m_count));

    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
